inst_fetch_queue: RTL

- Instruction fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter, drives the Imem read address, and captures the returned instruction word together with its PC into a small FIFO.
- Presents the queue head to decode through a valid/ready handshake; accepts branch/jump redirects that flush the queue.
- Imem is a combinational read: the word for o_imem_addr is valid in the same cycle.

---
 rtl/inst_fetch_queue.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the PC, reads a combinational Imem and queues {pc, inst} for decode.
// Optional misaligned-redirect detection and fetch freeze under `FETCH_MISALIGN_CHECK_EN.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module inst_fetch_queue #(
  parameter int unsigned                 ADDR_WIDTH = `ADDR_WIDTH,
  parameter int unsigned                 INST_WIDTH = `INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]       RESET_PC   = '0,
  parameter int unsigned                 DEPTH      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic [ADDR_WIDTH-1:0] o_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                  o_misaligned
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  logic valid;
  logic pop;
  logic push;
  logic frozen;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  assign frozen       = misaligned_q;
  assign o_misaligned = misaligned_q;
  // Flag tracks the alignment of the most recent redirect target.
  assign misaligned_d = i_redirect ? (|i_redirect_pc[1:0]) : misaligned_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end
`else
  logic unused_redirect_lsbs;

  assign frozen               = 1'b0;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];
`endif

  always_comb begin
    valid    = (cnt_q != '0);
    pop      = valid & i_ready;
    push     = !i_redirect & !frozen & ((cnt_q < DepthCnt) | pop);

    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;

    if (i_redirect) begin
      // A pop in this cycle is still consumed by decode; the flush discards everything else.
      pc_d     = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        pc_d     = pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: head outputs are gated to zero while the queue is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= i_imem_inst;
    end
  end

  always_comb begin
    o_imem_addr = pc_q;
    o_valid     = valid;
    o_inst      = valid ? inst_mem[rd_ptr_q] : '0;
    o_pc        = valid ? pc_mem[rd_ptr_q] : '0;
    o_pc_plus4  = o_pc + ADDR_WIDTH'(4);
  end

endmodule
